// File: rtl/uart_auth_rx.sv
// uart_auth_rx: UART receiver plus rider authorization FSM for the Segway.
// Receives 8N1 bytes from the BLE module, decodes 'G' (authorize) and
// 'S' (stop), and produces pwr_up to gate balance control and motor drive.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   RX         serial data in, idles high, asynchronous to clk
//   rider_off  load cells report no rider (synchronous to clk)
//   pwr_up     authorization granted (registered, state != OFF)
//   rx_data    last correctly framed byte
//   rx_rdy     one-cycle pulse when rx_data updates
//   frame_err  one-cycle pulse when the stop bit samples low
module uart_auth_rx #(
   parameter int unsigned BAUD_DIV = 2604,
   parameter logic [7:0]  CMD_GO   = 8'h47,
   parameter logic [7:0]  CMD_STOP = 8'h53
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       rider_off,
   output logic       pwr_up,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       frame_err
);

   localparam logic [11:0] FULL_CNT = 12'(BAUD_DIV);
   localparam logic [11:0] HALF_CNT = 12'(BAUD_DIV / 2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

   // ---------------- RX synchronizer ----------------
   logic rx_ff1, rx_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ff1 <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         rx_ff1 <= RX;
         rx_s   <= rx_ff1;
      end
   end

   // ---------------- Receiver FSM ----------------
   rx_state_t   rx_state, rx_nxt;
   logic [11:0] baud_cnt, cnt_nxt;
   logic [2:0]  bit_cnt, bit_nxt;
   logic [7:0]  shreg, sh_nxt;
   logic        rdy_nxt, ferr_nxt;
   logic        expire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state  <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_rdy    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_state  <= rx_nxt;
         baud_cnt  <= cnt_nxt;
         bit_cnt   <= bit_nxt;
         shreg     <= sh_nxt;
         rx_rdy    <= rdy_nxt;
         frame_err <= ferr_nxt;
         if (rdy_nxt)
            rx_data <= shreg;
      end
   end

   always_comb begin
      rx_nxt   = rx_state;
      cnt_nxt  = baud_cnt;
      bit_nxt  = bit_cnt;
      sh_nxt   = shreg;
      rdy_nxt  = 1'b0;
      ferr_nxt = 1'b0;
      // counter only runs outside IDLE, so expiry is qualified by state below
      expire   = (baud_cnt == '0);
      unique case (rx_state)
         IDLE: begin
            if (!rx_s) begin
               cnt_nxt = HALF_CNT;
               rx_nxt  = START;
            end
         end
         START: begin
            if (expire) begin
               if (rx_s) begin
                  rx_nxt = IDLE;
               end else begin
                  cnt_nxt = FULL_CNT;
                  bit_nxt = '0;
                  rx_nxt  = DATA;
               end
            end else begin
               cnt_nxt = baud_cnt - 12'd1;
            end
         end
         DATA: begin
            if (expire) begin
               sh_nxt  = {rx_s, shreg[7:1]};
               bit_nxt = bit_cnt + 3'd1;
               cnt_nxt = FULL_CNT;
               if (bit_cnt == 3'd7)
                  rx_nxt = STOP;
            end else begin
               cnt_nxt = baud_cnt - 12'd1;
            end
         end
         STOP: begin
            if (expire) begin
               rx_nxt = IDLE;
               if (rx_s)
                  rdy_nxt = 1'b1;
               else
                  ferr_nxt = 1'b1;
            end else begin
               cnt_nxt = baud_cnt - 12'd1;
            end
         end
         default: rx_nxt = IDLE;
      endcase
   end

   // ---------------- Authorization FSM ----------------
   auth_state_t auth_state, auth_nxt;
   logic        go, stop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         auth_state <= OFF;
         pwr_up     <= 1'b0;
      end else begin
         auth_state <= auth_nxt;
         // registered from next state so pwr_up tracks the state register
         pwr_up     <= (auth_nxt != OFF);
      end
   end

   always_comb begin
      go       = rx_rdy && (rx_data == CMD_GO);
      stop     = rx_rdy && (rx_data == CMD_STOP);
      auth_nxt = auth_state;
      unique case (auth_state)
         OFF:  if (go) auth_nxt = PWR1;
         PWR1: if (stop) auth_nxt = rider_off ? OFF : PWR2;
         PWR2: begin
            if (go)
               auth_nxt = PWR1;
            else if (rider_off)
               auth_nxt = OFF;
         end
         default: auth_nxt = OFF;
      endcase
   end

endmodule

// File: tb/tb_uart_auth_rx.sv
module tb_uart_auth_rx;

   localparam int unsigned BIT = 64;
   localparam logic [7:0]  G   = 8'h47;
   localparam logic [7:0]  S   = 8'h53;

   logic       clk = 1'b0;
   logic       rst;
   logic       RX;
   logic       rider_off;
   logic       pwr_up;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       frame_err;

   uart_auth_rx #(.BAUD_DIV(BIT), .CMD_GO(G), .CMD_STOP(S)) dut (
      .clk(clk), .rst(rst), .RX(RX), .rider_off(rider_off),
      .pwr_up(pwr_up), .rx_data(rx_data), .rx_rdy(rx_rdy), .frame_err(frame_err)
   );

   always #10 clk = ~clk;

   typedef struct {
      bit         ferr;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   vec_count  = 0;
   int   fail_count = 0;

   // reference model of the authorization policy
   bit         powered  = 0;
   bit         stop_req = 0;
   logic [7:0] last_good = 8'h00;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vec_count++;
      if (act !== exp) begin
         fail_count++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compares pulses against the scoreboard and pwr_up against the model.
   always @(negedge clk) begin
      exp_t       e;
      bit         got;
      logic [7:0] b;
      got = 0;
      b   = 8'h00;
      if (rst) begin
         powered   = 0;
         stop_req  = 0;
         last_good = 8'h00;
      end
      chk("pwr_up", {7'b0, pwr_up}, {7'b0, powered});
      if (!rst) begin
         if (rx_rdy && frame_err)
            chk("rdy_and_ferr_together", 8'h01, 8'h00);
         if (rx_rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rx_rdy", rx_data, 8'hxx);
            end else begin
               e = exp_q.pop_front();
               chk("rx_rdy_kind", {7'b0, e.ferr}, 8'h00);
               chk("rx_data", rx_data, e.data);
               last_good = e.data;
               got = 1;
               b   = e.data;
            end
         end
         if (frame_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame_err", rx_data, 8'hxx);
            end else begin
               e = exp_q.pop_front();
               chk("frame_err_kind", {7'b0, e.ferr}, 8'h01);
               chk("rx_data_after_ferr", rx_data, last_good);
            end
         end
         if (got && b == G) begin
            powered  = 1;
            stop_req = 0;
         end else if (got && b == S && powered && !stop_req) begin
            if (rider_off) powered = 0;
            else           stop_req = 1;
         end else if (stop_req && rider_off) begin
            powered  = 0;
            stop_req = 0;
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      exp_t e;
      e.ferr = !stop_ok;
      e.data = b;
      exp_q.push_back(e);
      RX = 1'b0;
      cyc(BIT);
      for (int unsigned i = 0; i < 8; i++) begin
         RX = b[i];
         cyc(BIT);
      end
      RX = stop_ok;
      cyc(BIT);
      RX = 1'b1;
      cyc(3 * BIT);
   endtask

   task automatic glitch(input int unsigned len);
      RX = 1'b0;
      cyc(len);
      RX = 1'b1;
      cyc(2 * BIT);
   endtask

   initial begin
      #(20 * 150000);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rb;
      logic [7:0] mid;
      rst = 1'b1;
      RX = 1'b1;
      rider_off = 1'b1;
      cyc(5);
      rst = 1'b0;
      cyc(2000);
      chk("idle_pwr_up",    {7'b0, pwr_up},    8'h00);
      chk("idle_rx_rdy",    {7'b0, rx_rdy},    8'h00);
      chk("idle_frame_err", {7'b0, frame_err}, 8'h00);
      chk("idle_rx_data",   rx_data,           8'h00);

      // authorize, then rider_off wanders while riding
      send_frame(G, 1);
      repeat (50) begin
         rider_off = 1'($urandom);
         cyc(100);
      end

      // stop with rider on, hold, then step off
      rider_off = 1'b0;
      send_frame(S, 1);
      cyc(5000);
      rider_off = 1'b1;
      cyc(200);

      // stop with rider already off
      rider_off = 1'b0;
      send_frame(G, 1);
      rider_off = 1'b1;
      send_frame(S, 1);
      cyc(200);

      // re-authorize from PWR2 and ignored bytes
      send_frame(G, 1);
      rider_off = 1'b0;
      send_frame(S, 1);
      send_frame(G, 1);
      rider_off = 1'b1;
      cyc(500);
      send_frame(8'h41, 1);
      chk("pwr_after_ignored", {7'b0, pwr_up}, 8'h01);

      // framing error on an 'S' must not change state or rx_data
      send_frame(S, 0);
      chk("pwr_after_ferr", {7'b0, pwr_up}, 8'h01);
      chk("rx_data_kept", rx_data, 8'h41);

      // short RX glitch
      glitch(BIT / 4);

      // reset mid-byte, after bit 4
      mid = G;
      RX = 1'b0;
      cyc(BIT);
      for (int unsigned i = 0; i < 5; i++) begin
         RX = mid[i];
         cyc(BIT);
      end
      rst = 1'b1;
      RX = 1'b1;
      #1;
      chk("rst_pwr_up",    {7'b0, pwr_up},    8'h00);
      chk("rst_rx_data",   rx_data,           8'h00);
      chk("rst_rx_rdy",    {7'b0, rx_rdy},    8'h00);
      chk("rst_frame_err", {7'b0, frame_err}, 8'h00);
      exp_q.delete();
      cyc(3);
      rst = 1'b0;
      cyc(3 * BIT);
      send_frame(G, 1);
      chk("rx_data_after_rst", rx_data, G);

      // randomized traffic
      repeat (30) begin
         case ($urandom_range(0, 4))
            0: rb = G;
            1: rb = S;
            2: rb = 8'h41;
            default: rb = 8'($urandom);
         endcase
         rider_off = 1'($urandom);
         if ($urandom_range(0, 5) == 0)
            glitch($urandom_range(1, BIT / 2 - 6));
         send_frame(rb, $urandom_range(0, 7) != 0);
         if ($urandom_range(0, 1) == 1) begin
            rider_off = 1'($urandom);
            cyc($urandom_range(1, 300));
         end
      end

      cyc(4 * BIT);
      vec_count++;
      if (exp_q.size() != 0) begin
         fail_count++;
         $display("FAIL pending_expectations: got %0d left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
      $finish;
   end

endmodule

// File: doc/uart_auth_rx.md
Name: uart_auth_rx

Overview:
- Receives the BLE module's serial command stream and runs the rider authorization state machine.
- Produces pwr_up, which gates the balance controller and motor drive in the Segway top level.
- Sits directly downstream of the host-side UART transmitter and upstream of the steering/balance power gating.
- Combines a UART receiver, a 'G'/'S' command decoder and a three-state power FSM.

Parameters:
- BAUD_DIV, 2604: clocks per bit (50 MHz / 19200 baud). Legal range 16 to 4095.
- CMD_GO, 8'h47: ASCII 'G', the authorize command.
- CMD_STOP, 8'h53: ASCII 'S', the stop command.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous active-high reset
- RX  input  1  serial data from BLE module; idles high; asynchronous to clk
- rider_off  input  1  high when the load cells report no rider; synchronous to clk
- pwr_up  output  1  authorization granted; enables balance control and motors
- rx_data  output  8  last correctly framed byte received
- rx_rdy  output  1  one-cycle pulse when rx_data is updated
- frame_err  output  1  one-cycle pulse when the stop bit samples low

Behaviour:
- Reset is asynchronous and active-high. It clears:
  - both RX synchronizer flops, to 1 (idle level);
  - the receiver FSM, to IDLE;
  - the authorization FSM, to OFF.
- Reset values of outputs: pwr_up=0, rx_data=8'h00, rx_rdy=0, frame_err=0.
- If reset asserts mid-frame, the partial byte is discarded and no pulse is produced.
- RX path: two-flop synchronizer. All receiver decisions use the second flop (rx_s).
- Receiver FSM, states IDLE, START, DATA, STOP:
  - IDLE: when rx_s=0, load baud counter with BAUD_DIV/2 (integer division) and go to START.
  - START: when the counter expires, sample rx_s.
    - If 1: treat as a glitch and return to IDLE.
    - If 0: load BAUD_DIV and go to DATA.
  - DATA: sample rx_s at each counter expiry and shift it in LSB-first. The bit counter is 3 bits. After the 8th sample, load BAUD_DIV and go to STOP.
  - STOP: when the counter expires, sample rx_s.
    - If 1: rx_data is loaded with the shift register and rx_rdy pulses on the following cycle.
    - If 0: frame_err pulses and rx_data is unchanged.
    - Either way, return to IDLE. A new start bit is accepted on the next cycle.
- Baud counter: 12-bit down-counter. Expiry means count==0 while a decrement is enabled. There is no wrap-around; it reloads on every expiry.
- Command decode is evaluated only in the rx_rdy cycle:
  - go = (rx_data==CMD_GO)
  - stop = (rx_data==CMD_STOP)
  - Any other byte is ignored by the authorization FSM.
- Authorization FSM, states OFF, PWR1, PWR2:
  - OFF: on go, enter PWR1. A go is accepted regardless of rider_off.
  - PWR1 (riding):
    - stop with rider_off=1: enter OFF.
    - stop with rider_off=0: enter PWR2.
    - rider_off alone never leaves PWR1.
  - PWR2 (stop requested, rider on):
    - rider_off=1: enter OFF.
    - go: enter PWR1.
    - If go and rider_off=1 occur in the same cycle, go wins and the FSM enters PWR1.
  - Repeated go in PWR1, or repeated stop in PWR2, has no effect.
- pwr_up is registered and equals (state != OFF).
- Latency:
  - pwr_up rises 1 clk after the rx_rdy pulse.
  - pwr_up falls 1 clk after rider_off is sampled high in PWR2.
  - rx_rdy pulses 1 clk after the mid-stop-bit sample, which is about 9.5 bit times (about 24,740 clks) after the RX falling edge, plus 2 synchronizer clks.
- rx_rdy and frame_err are never high in the same cycle.

Test Plan:
- Post-reset idle: rst pulse, RX=1, rider_off=1, 2000 clks -> pwr_up=0, rx_rdy=0, frame_err=0, rx_data=8'h00.
- Authorize: send 8'h47 at 19200 baud -> rx_rdy single pulse with rx_data=8'h47; pwr_up=1 on the next clk and holds 300,000 clks while rider_off toggles.
- Stop with rider on, then step off:
  - from PWR1, rider_off=0, send 8'h53 -> pwr_up stays 1 for 5000+ clks;
  - set rider_off=1 -> pwr_up=0 exactly 1 clk later.
- Stop with rider already off: from PWR1 with rider_off=1, send 8'h53 -> pwr_up=0 one clk after rx_rdy.
- Re-authorize and ignored bytes:
  - from PWR2 send 8'h47 -> PWR1, pwr_up stays 1; a later rider_off=1 does not drop it;
  - send 8'h41 -> rx_rdy pulses, pwr_up unchanged.
- Error and glitch handling:
  - frame with stop bit forced 0 -> frame_err pulse, no rx_rdy, rx_data unchanged, FSM state unchanged;
  - RX low pulse of 500 clks -> no pulse of either kind;
  - rst asserted mid-byte (after bit 4) -> all outputs 0 immediately; the next full 8'h47 frame is received correctly.
